// File: rtl/rf_wb_arbiter_if.sv
// Write-back arbiter bus: two write requesters, decode reservations, scoreboard and RF write port.
// Forwarding signals exist only when RF_WB_FWD_EN is defined.
interface rf_wb_arbiter_if #(
    parameter int DW   = 32,
    parameter int NREG = 32
);
    logic            a_valid;
    logic [4:0]      a_addr;
    logic [DW-1:0]   a_data;
    logic            a_ready;

    logic            b_valid;
    logic [4:0]      b_addr;
    logic [DW-1:0]   b_data;
    logic            b_ready;

    logic            alloc_valid;
    logic [4:0]      alloc_addr;
    logic            alloc_ready;

    logic [NREG-1:0] busy;

    logic [4:0]      rf_dst_addr;
    logic [DW-1:0]   rf_dst_data;
    logic            rf_reg_write;

`ifdef RF_WB_FWD_EN
    logic [4:0]      rd_src_addr;
    logic [4:0]      rd_tar_addr;
    logic            fwd_src_hit;
    logic            fwd_tar_hit;
    logic [DW-1:0]   fwd_data;
`endif

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        input  alloc_valid, alloc_addr,
`ifdef RF_WB_FWD_EN
        input  rd_src_addr, rd_tar_addr,
        output fwd_src_hit, fwd_tar_hit, fwd_data,
`endif
        output a_ready, b_ready, alloc_ready, busy,
        output rf_dst_addr, rf_dst_data, rf_reg_write
    );

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        output alloc_valid, alloc_addr,
`ifdef RF_WB_FWD_EN
        output rd_src_addr, rd_tar_addr,
        input  fwd_src_hit, fwd_tar_hit, fwd_data,
`endif
        input  a_ready, b_ready, alloc_ready, busy,
        input  rf_dst_addr, rf_dst_data, rf_reg_write
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter for the RF write port plus a per-register busy scoreboard.
// Define RF_WB_FWD_EN to add combinational forwarding of the registered write to two read ports.
module rf_wb_arbiter #(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    rf_wb_arbiter_if.slave wb,
    output logic           dbg_last
);

    // Handshake: a requester raises valid with addr/data and holds all three until it sees
    // ready in the same cycle; the transfer happens on the edge closing that cycle.
    typedef enum logic {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } last_e;

    last_e           last_q, last_d;
    logic            grant_a, grant_b;
    logic [4:0]      dst_addr_q, dst_addr_d;
    logic [DW-1:0]   dst_data_q, dst_data_d;
    logic            reg_write_q, reg_write_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic            alloc_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q      <= LAST_B;
            dst_addr_q  <= '0;
            dst_data_q  <= '0;
            reg_write_q <= 1'b0;
            busy_q      <= '0;
        end else begin
            last_q      <= last_d;
            dst_addr_q  <= dst_addr_d;
            dst_data_q  <= dst_data_d;
            reg_write_q <= reg_write_d;
            busy_q      <= busy_d;
        end
    end

    // Pointer FSM: a lone requester always wins; on contention the one not granted last wins.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        last_d  = last_q;
        if (rst_n) begin
            if (wb.a_valid && (!wb.b_valid || last_q == LAST_B)) begin
                grant_a = 1'b1;
                last_d  = LAST_A;
            end else if (wb.b_valid) begin
                grant_b = 1'b1;
                last_d  = LAST_B;
            end
        end
    end

    // Register 0 writes still consume the slot but never reach the RF.
    always_comb begin
        dst_addr_d  = dst_addr_q;
        dst_data_d  = dst_data_q;
        reg_write_d = 1'b0;
        if (grant_a) begin
            dst_addr_d  = wb.a_addr;
            dst_data_d  = wb.a_data;
            reg_write_d = (wb.a_addr != 5'd0);
        end else if (grant_b) begin
            dst_addr_d  = wb.b_addr;
            dst_data_d  = wb.b_data;
            reg_write_d = (wb.b_addr != 5'd0);
        end
    end

    assign alloc_ok = !busy_q[wb.alloc_addr] || (wb.alloc_addr == 5'd0);

    // A reservation landing on the same edge as the retiring write must survive, so set follows clear.
    always_comb begin
        busy_d = busy_q;
        if (reg_write_q) begin
            busy_d[dst_addr_q] = 1'b0;
        end
        if (wb.alloc_valid && alloc_ok && (wb.alloc_addr != 5'd0)) begin
            busy_d[wb.alloc_addr] = 1'b1;
        end
    end

    assign wb.a_ready      = grant_a;
    assign wb.b_ready      = grant_b;
    assign wb.alloc_ready  = alloc_ok;
    assign wb.busy         = busy_q;
    assign wb.rf_dst_addr  = dst_addr_q;
    assign wb.rf_dst_data  = dst_data_q;
    assign wb.rf_reg_write = reg_write_q;
    assign dbg_last        = last_q;

`ifdef RF_WB_FWD_EN
    // Covers the RF read that samples on the same edge the write commits.
    assign wb.fwd_src_hit = reg_write_q && (dst_addr_q == wb.rd_src_addr) && (wb.rd_src_addr != 5'd0);
    assign wb.fwd_tar_hit = reg_write_q && (dst_addr_q == wb.rd_tar_addr) && (wb.rd_tar_addr != 5'd0);
    assign wb.fwd_data    = dst_data_q;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed sequences plus a per-cycle reference model
// whose expected RF-port values flow through exp_q.
module tb_rf_wb_arbiter;
    localparam int DW   = 32;
    localparam int NREG = 32;
    localparam int EW   = 1 + 5 + DW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic dbg_last;

    int n_checks = 0;
    int n_errors = 0;

    logic [EW-1:0] exp_q[$];
    logic          grant_log[$];

    logic            m_init      = 1'b0;
    logic            m_last      = 1'b1;
    logic            m_wr        = 1'b0;
    logic [4:0]      m_addr      = '0;
    logic [4:0]      m_hold_addr = '0;
    logic [DW-1:0]   m_hold_data = '0;
    logic [NREG-1:0] m_busy      = '0;

    rf_wb_arbiter_if #(.DW(DW), .NREG(NREG)) wb ();

    rf_wb_arbiter #(.NREG(NREG), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb       (wb),
        .dbg_last (dbg_last)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    a_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (wb.a_valid && !wb.a_ready) |=> (wb.a_valid && $stable(wb.a_addr) && $stable(wb.a_data)));
    b_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (wb.b_valid && !wb.b_ready) |=> (wb.b_valid && $stable(wb.b_addr) && $stable(wb.b_data)));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drive_a(input logic [4:0] addr, input logic [DW-1:0] data, output int waits);
        waits = 0;
        wb.a_valid = 1'b1;
        wb.a_addr  = addr;
        wb.a_data  = data;
        @(negedge clk);
        while (!wb.a_ready && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        if (!wb.a_ready) check("a_grant_timeout", 64'(waits), 64'd0);
        @(posedge clk);
        #1;
        wb.a_valid = 1'b0;
    endtask

    task automatic drive_b(input logic [4:0] addr, input logic [DW-1:0] data, output int waits);
        waits = 0;
        wb.b_valid = 1'b1;
        wb.b_addr  = addr;
        wb.b_data  = data;
        @(negedge clk);
        while (!wb.b_ready && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        if (!wb.b_ready) check("b_grant_timeout", 64'(waits), 64'd0);
        @(posedge clk);
        #1;
        wb.b_valid = 1'b0;
    endtask

    task automatic do_alloc(input logic [4:0] addr, output logic acc);
        wb.alloc_valid = 1'b1;
        wb.alloc_addr  = addr;
        @(negedge clk);
        acc = wb.alloc_ready;
        @(posedge clk);
        #1;
        wb.alloc_valid = 1'b0;
    endtask

    // Reference model, evaluated mid-cycle: checks the RF port against the entry queued one
    // cycle earlier, checks the readies and scoreboard, then queues the next expected RF port.
    always @(negedge clk) begin : model
        logic            ga, gb, ar;
        logic [EW-1:0]   e;
        logic [NREG-1:0] nb;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rf_reg_write", 64'(wb.rf_reg_write), 64'(e[EW-1]));
            check("rf_dst_addr", 64'(wb.rf_dst_addr), 64'(e[EW-2 -: 5]));
            check("rf_dst_data", 64'(wb.rf_dst_data), 64'(e[DW-1:0]));
            m_wr   = e[EW-1];
            m_addr = e[EW-2 -: 5];
        end
        ga = 1'b0;
        gb = 1'b0;
        if (rst_n) begin
            ga = wb.a_valid && (!wb.b_valid || m_last);
            gb = wb.b_valid && !ga;
        end
        check("a_ready", 64'(wb.a_ready), 64'(ga));
        check("b_ready", 64'(wb.b_ready), 64'(gb));
        ar = 1'b1;
        if (m_init) begin
            ar = !m_busy[wb.alloc_addr] || (wb.alloc_addr == 5'd0);
            check("busy", 64'(wb.busy), 64'(m_busy));
            check("alloc_ready", 64'(wb.alloc_ready), 64'(ar));
        end
        if (!rst_n) begin
            m_init      = 1'b1;
            m_last      = 1'b1;
            m_busy      = '0;
            m_hold_addr = '0;
            m_hold_data = '0;
            exp_q.push_back({1'b0, 5'd0, {DW{1'b0}}});
        end else begin
            nb = m_busy;
            if (m_wr) nb[m_addr] = 1'b0;
            if (wb.alloc_valid && ar && (wb.alloc_addr != 5'd0)) nb[wb.alloc_addr] = 1'b1;
            m_busy = nb;
            if (ga) begin
                m_last      = 1'b0;
                m_hold_addr = wb.a_addr;
                m_hold_data = wb.a_data;
                grant_log.push_back(1'b0);
                exp_q.push_back({wb.a_addr != 5'd0, wb.a_addr, wb.a_data});
            end else if (gb) begin
                m_last      = 1'b1;
                m_hold_addr = wb.b_addr;
                m_hold_data = wb.b_data;
                grant_log.push_back(1'b1);
                exp_q.push_back({wb.b_addr != 5'd0, wb.b_addr, wb.b_data});
            end else begin
                exp_q.push_back({1'b0, m_hold_addr, m_hold_data});
            end
        end
    end

    initial begin
        int   w;
        logic acc;
        wb.a_valid     = 1'b0;
        wb.a_addr      = '0;
        wb.a_data      = '0;
        wb.b_valid     = 1'b0;
        wb.b_addr      = '0;
        wb.b_data      = '0;
        wb.alloc_valid = 1'b0;
        wb.alloc_addr  = '0;
`ifdef RF_WB_FWD_EN
        wb.rd_src_addr = '0;
        wb.rd_tar_addr = '0;
`endif

        // Reset state
        do_reset(2);
        @(negedge clk);
        check("rst_reg_write", 64'(wb.rf_reg_write), 64'd0);
        check("rst_dst_addr", 64'(wb.rf_dst_addr), 64'd0);
        check("rst_dst_data", 64'(wb.rf_dst_data), 64'd0);
        check("rst_busy", 64'(wb.busy), 64'd0);
        check("rst_last", 64'(dbg_last), 64'd1);
        step();

        // Single write from A
        drive_a(5'd5, 32'hDEADBEEF, w);
        check("single_wait", 64'(w), 64'd0);
        @(negedge clk);
        check("single_we", 64'(wb.rf_reg_write), 64'd1);
        check("single_addr", 64'(wb.rf_dst_addr), 64'd5);
        check("single_data", 64'(wb.rf_dst_data), 64'hDEADBEEF);
        @(negedge clk);
        check("single_we_off", 64'(wb.rf_reg_write), 64'd0);
        step();

        // Contention right after reset: A,B,A,B
        do_reset(1);
        grant_log.delete();
        fork
            begin
                int wa;
                drive_a(5'd3, 32'h11, wa);
                drive_a(5'd3, 32'h11, wa);
            end
            begin
                int wb_n;
                drive_b(5'd4, 32'h22, wb_n);
                drive_b(5'd4, 32'h22, wb_n);
            end
        join
        check("rr_count", 64'(grant_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
            check($sformatf("rr_order_%0d", i), 64'(grant_log[i]), 64'(i % 2));
        end

        // Register 0 write is granted but never committed
        drive_b(5'd0, 32'hFFFFFFFF, w);
        check("zero_wait", 64'(w), 64'd0);
        @(negedge clk);
        check("zero_we", 64'(wb.rf_reg_write), 64'd0);
        check("zero_busy", 64'(wb.busy), 64'd0);
        step();

        // Scoreboard stall on register 7
        do_alloc(5'd7, acc);
        check("alloc7_acc", 64'(acc), 64'd1);
        @(negedge clk);
        check("alloc7_busy", 64'(wb.busy[7]), 64'd1);
        step();
        do_alloc(5'd7, acc);
        check("alloc7_stall", 64'(acc), 64'd0);
        drive_a(5'd7, 32'h77, w);
        do_alloc(5'd7, acc);
        check("alloc7_during_clear", 64'(acc), 64'd0);
        do_alloc(5'd7, acc);
        check("alloc7_after_clear", 64'(acc), 64'd1);
        @(negedge clk);
        check("alloc7_rebusy", 64'(wb.busy[7]), 64'd1);
        step();
        drive_a(5'd7, 32'h78, w);
        drive_a(5'd7, 32'h79, w);
        do_alloc(5'd7, acc);
        check("set_clear_acc", 64'(acc), 64'd1);
        @(negedge clk);
        check("set_wins", 64'(wb.busy[7]), 64'd1);
        step();
        drive_a(5'd7, 32'h7A, w);
        step();
        @(negedge clk);
        check("busy_drained", 64'(wb.busy), 64'd0);
        step();

        // Mid-operation reset with both requesters valid and a live reservation
        do_alloc(5'd12, acc);
        check("alloc12_acc", 64'(acc), 64'd1);
        grant_log.delete();
        fork
            begin
                int wa;
                drive_a(5'd1, 32'h101, wa);
            end
            begin
                int wb_n;
                drive_b(5'd2, 32'h202, wb_n);
            end
            begin
                rst_n = 1'b0;
                @(negedge clk);
                check("rst_a_ready", 64'(wb.a_ready), 64'd0);
                check("rst_b_ready", 64'(wb.b_ready), 64'd0);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                @(negedge clk);
                check("midrst_busy", 64'(wb.busy), 64'd0);
                check("midrst_we", 64'(wb.rf_reg_write), 64'd0);
            end
        join
        check("midrst_count", 64'(grant_log.size()), 64'd2);
        if (grant_log.size() > 0) check("midrst_first_a", 64'(grant_log[0]), 64'd0);
        step();

`ifdef RF_WB_FWD_EN
        drive_a(5'd9, 32'hCAFE, w);
        wb.rd_src_addr = 5'd9;
        wb.rd_tar_addr = 5'd0;
        @(negedge clk);
        check("fwd_src_hit", 64'(wb.fwd_src_hit), 64'd1);
        check("fwd_data", 64'(wb.fwd_data), 64'hCAFE);
        check("fwd_tar_zero", 64'(wb.fwd_tar_hit), 64'd0);
        step();
        wb.rd_src_addr = 5'd0;
        @(negedge clk);
        check("fwd_src_zero", 64'(wb.fwd_src_hit), 64'd0);
        step();
`endif

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and scoreboard for the 32-entry register file. Two write-back requesters share the RF's single write port: requester A is the ALU path and requester B is the load/memory path. The block grants them round-robin and drives the RF write port from a registered output stage. It also keeps a per-register busy scoreboard so decode can stall on pending destinations. It sits between the execute/memory stages and the RF write port.

## Interface
Parameters:
- NREG, 32, number of architectural registers (address width fixed at 5)
- DW, 32, data width

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- a_valid  in  1  requester A has a write pending
- a_addr  in  5  requester A destination register
- a_data  in  32  requester A write data
- a_ready  out  1  requester A write accepted this cycle
- b_valid, b_addr, b_data, b_ready  same as A, for requester B
- alloc_valid  in  1  decode reserves a destination register
- alloc_addr  in  5  register to reserve
- alloc_ready  out  1  reservation accepted this cycle
- busy  out  32  scoreboard, bit i = register i has an outstanding write
- rf_dst_addr  out  5  to RF dst_addr
- rf_dst_data  out  32  to RF dst_data
- rf_reg_write  out  1  to RF reg_write
- Only with RF_WB_FWD_EN: rd_src_addr, rd_tar_addr in 5 each; fwd_src_hit, fwd_tar_hit out 1 each; fwd_data out 32.

## Operation
- Arbitration state is a 1-bit pointer `last`: 0 = A granted last, 1 = B granted last.
  - When only one requester is valid, that requester is granted.
  - When both are valid, the requester not equal to `last` is granted.
  - `last` updates only on a grant.
- At most one requester is granted per cycle. Its ready is asserted combinationally in that cycle; the other ready is 0.
- A requester holds valid, addr and data stable until it sees ready. Dropping valid before ready is illegal; the bench flags it with an assertion.
- On the edge that closes the grant cycle, the output stage captures addr and data, and sets rf_reg_write=1.
  - If there is no grant, rf_reg_write=0 and addr/data hold their previous values.
- A write to register 0 is granted normally and consumes a slot, but rf_reg_write is forced to 0.
- Scoreboard:
  - A bit clears on the edge where rf_reg_write=1 with rf_dst_addr=i.
  - A bit sets on the edge where alloc_valid && alloc_ready with alloc_addr=i, for i≠0.
  - alloc_ready = !busy[alloc_addr] || alloc_addr==0.
  - If set and clear hit the same bit on one edge, set wins: the new reservation survives.
- Reset (rst_n=0 at an edge):
  - Clears busy, `last`=1 (so A is favoured first), rf_reg_write=0, rf_dst_addr=0, rf_dst_data=0.
  - The readies are combinational and are 0 during reset.
  - An in-flight grant is discarded; a write captured before reset is not replayed.

## Timing
- Grant in cycle N: rf_reg_write=1 during cycle N+1. The RF commits at the end of N+1, so write latency is 2 edges from ready.
- The busy bit clears at the end of N+1. From N+2 onward, a new alloc to the same register is accepted.
- Throughput is 1 write per cycle sustained. With both requesters continuously valid, grants alternate A,B,A,B.
- alloc_ready depends combinationally on the busy register only, with no input-to-output path from the requesters.

## Configuration
- RF_WB_FWD_EN defined:
  - fwd_src_hit = rf_reg_write && rf_dst_addr==rd_src_addr && rd_src_addr≠0.
  - fwd_tar_hit is the same comparison for rd_tar_addr.
  - fwd_data = rf_dst_data. All three outputs are combinational.
  - This covers the RF's same-edge read/write case, where the registered read returns the old value.
- RF_WB_FWD_EN undefined: the forwarding ports and comparators are absent. Consumers rely on the scoreboard stall.

## Test plan
- Reset then single write: a_valid=1, a_addr=5, a_data=0xDEADBEEF for one cycle → a_ready=1 in N; rf_reg_write=1, rf_dst_addr=5, rf_dst_data=0xDEADBEEF in N+1; 0 in N+2.
- Contention: A (addr 3, 0x11) and B (addr 4, 0x22) valid continuously for 4 cycles after reset → grant order A,B,A,B; rf_dst_addr sequence 3,4,3,4, one per cycle.
- Zero register: b_addr=0, b_data=0xFFFFFFFF → b_ready=1; rf_reg_write stays 0; busy stays 0.
- Scoreboard stall:
  - alloc 7 → busy[7]=1 next cycle.
  - Second alloc 7 → alloc_ready=0 until A writes addr 7.
  - Bit clears at the end of the rf_reg_write cycle; alloc_ready=1 the following cycle.
  - Simultaneous clear and re-alloc of 7 leaves busy[7]=1.
- Mid-operation reset: both valid, assert rst_n=0 for one cycle → busy=0, rf_reg_write=0, readies 0 during reset; first grant after release goes to A.
- RF_WB_FWD_EN: rd_src_addr=9 while rf_reg_write=1, rf_dst_addr=9, data 0xCAFE → fwd_src_hit=1, fwd_data=0xCAFE; rd_src_addr=0 → hit=0.
